// File: rtl/decode_stage_pkg.sv
// Shared types for the RV32I decode stage: the decoded control bundle and its encodings.
package decode_stage_pkg;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b1000;

  localparam logic [1:0] BrNone = 2'd0;
  localparam logic [1:0] BrCond = 2'd1;
  localparam logic [1:0] BrJal  = 2'd2;
  localparam logic [1:0] BrJalr = 2'd3;

  // aluin1_m: operand 1 forced to zero; aluPC_m: operand 1 is PC;
  // aluImm_m: operand 2 is imm; aluin2_m: operand 2 is the constant 4 (link address)
  typedef struct packed {
    logic [2:0]  func3;
    logic [31:0] imm;
    logic [3:0]  alu_codes;
    logic [1:0]  branch_type;
    logic        Wmem;
    logic        Wreg;
    logic        isLoad;
    logic        aluin1_m;
    logic        aluin2_m;
    logic        aluPC_m;
    logic        aluImm_m;
    logic        Rmem;
  } decoder_out_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_if #(
  parameter int unsigned PC_W = 32
);

  logic                          in_valid;
  logic                          in_ready;
  logic [31:0]                   in_instr;
  logic [PC_W-1:0]               in_pc;
  logic                          out_valid;
  logic                          out_ready;
  decode_stage_pkg::decoder_out_t out_ctrl;
  logic [4:0]                    out_rd;
  logic [4:0]                    out_rs1;
  logic [4:0]                    out_rs2;
  logic [PC_W-1:0]               out_pc;
  logic                          out_illegal;
  logic                          out_muldiv;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_ctrl, out_rd, out_rs1, out_rs2, out_pc, out_illegal,
           out_muldiv
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_ctrl, out_rd, out_rs1, out_rs2, out_pc, out_illegal,
           out_muldiv
  );

endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: instruction queue, combinational head decode, registered valid/ready output.
// Optional RV32M acceptance is enabled by defining DECODE_RV32M_EN.
module decode_stage #(
  parameter int unsigned IQ_DEPTH = 4,
  parameter int unsigned PC_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  decode_stage_if.slave                 bus,
  output logic [$clog2(IQ_DEPTH+1)-1:0] q_count
);
  import decode_stage_pkg::*;

  localparam int unsigned PtrW = $clog2(IQ_DEPTH);
  localparam int unsigned CntW = $clog2(IQ_DEPTH + 1);

  typedef enum logic {StEmpty, StFull} out_state_e;

  logic [31:0]     iq_instr_q [IQ_DEPTH];
  logic [PC_W-1:0] iq_pc_q    [IQ_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            push, load;
  out_state_e      state_q, state_d;

  logic [31:0]  instr;
  logic [6:0]   opcode, f7;
  logic [2:0]   f3;
  logic [31:0]  imm_i, imm_s, imm_b, imm_u, imm_j;
  decoder_out_t dec_ctrl, ctrl_q;
  logic         dec_illegal, dec_muldiv, illegal_q, muldiv_q;
  logic [4:0]   rd_q, rs1_q, rs2_q;
  logic [PC_W-1:0] pc_q;

  assign bus.in_ready = (count_q != CntW'(IQ_DEPTH));
  assign push         = bus.in_valid & bus.in_ready & ~flush;
  assign count_d      = count_q + CntW'(push) - CntW'(load);
  assign q_count      = count_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (load) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      iq_instr_q[wr_ptr_q] <= bus.in_instr;
      iq_pc_q[wr_ptr_q]    <= bus.in_pc;
    end
  end

  assign instr  = iq_instr_q[rd_ptr_q];
  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'h000};
  assign imm_j  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec_ctrl       = '0;
    dec_ctrl.func3 = f3;
    dec_illegal    = 1'b0;
    dec_muldiv     = 1'b0;
    case (opcode)
      7'b0110111: begin // LUI
        dec_ctrl.imm      = imm_u;
        dec_ctrl.aluin1_m = 1'b1;
        dec_ctrl.aluImm_m = 1'b1;
        dec_ctrl.Wreg     = 1'b1;
      end
      7'b0010111: begin // AUIPC
        dec_ctrl.imm      = imm_u;
        dec_ctrl.aluPC_m  = 1'b1;
        dec_ctrl.aluImm_m = 1'b1;
        dec_ctrl.Wreg     = 1'b1;
      end
      7'b1101111: begin // JAL
        dec_ctrl.imm         = imm_j;
        dec_ctrl.aluPC_m     = 1'b1;
        dec_ctrl.aluin2_m    = 1'b1;
        dec_ctrl.Wreg        = 1'b1;
        dec_ctrl.branch_type = BrJal;
      end
      7'b1100111: begin // JALR
        dec_ctrl.imm         = imm_i;
        dec_ctrl.aluPC_m     = 1'b1;
        dec_ctrl.aluin2_m    = 1'b1;
        dec_ctrl.Wreg        = 1'b1;
        dec_ctrl.branch_type = BrJalr;
        dec_illegal          = (f3 != 3'b000);
      end
      7'b1100011: begin // BRANCH
        dec_ctrl.imm         = imm_b;
        dec_ctrl.alu_codes   = AluSub;
        dec_ctrl.branch_type = BrCond;
        dec_illegal          = (f3 == 3'b010) || (f3 == 3'b011);
      end
      7'b0000011: begin // LOAD
        dec_ctrl.imm      = imm_i;
        dec_ctrl.aluImm_m = 1'b1;
        dec_ctrl.Wreg     = 1'b1;
        dec_ctrl.isLoad   = 1'b1;
        dec_ctrl.Rmem     = 1'b1;
        dec_illegal       = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      7'b0100011: begin // STORE
        dec_ctrl.imm      = imm_s;
        dec_ctrl.aluImm_m = 1'b1;
        dec_ctrl.Wmem     = 1'b1;
        dec_illegal       = (f3 >= 3'b011);
      end
      7'b0010011: begin // OPIMM
        dec_ctrl.imm      = imm_i;
        dec_ctrl.aluImm_m = 1'b1;
        dec_ctrl.Wreg     = 1'b1;
        if (f3 == 3'b101)      dec_ctrl.alu_codes = {instr[30], f3};
        else if (f3 == 3'b011) dec_ctrl.alu_codes = {1'b1, f3};
        else                   dec_ctrl.alu_codes = {1'b0, f3};
        dec_illegal = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
                      ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
      end
      7'b0110011: begin // OP
        dec_ctrl.alu_codes = {instr[30], f3};
        dec_ctrl.Wreg      = 1'b1;
        if (f7 == 7'b0000001) begin
`ifdef DECODE_RV32M_EN
          dec_muldiv         = 1'b1;
          dec_ctrl.alu_codes = AluAdd;
`else
          dec_illegal        = 1'b1;
`endif
        end else if (f7 == 7'b0100000) begin
          dec_illegal = (f3 != 3'b000) && (f3 != 3'b101);
        end else begin
          dec_illegal = (f7 != 7'b0000000);
        end
      end
      default: dec_illegal = 1'b1;
    endcase
    // Illegal words fall back to an inert OP bundle so nothing is written or branched on.
    if (dec_illegal) begin
      dec_ctrl           = '0;
      dec_ctrl.func3     = f3;
      dec_ctrl.alu_codes = {instr[30], f3};
      dec_muldiv         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StEmpty;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = (count_q != '0) && ((state_q == StEmpty) || bus.out_ready) && !flush;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: if (load) state_d = StFull;
        StFull:  if (bus.out_ready && !load) state_d = StEmpty;
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      pc_q      <= '0;
      illegal_q <= 1'b0;
      muldiv_q  <= 1'b0;
    end else if (load) begin
      ctrl_q    <= dec_ctrl;
      rd_q      <= instr[11:7];
      rs1_q     <= instr[19:15];
      rs2_q     <= instr[24:20];
      pc_q      <= iq_pc_q[rd_ptr_q];
      illegal_q <= dec_illegal;
      muldiv_q  <= dec_muldiv;
    end
  end

  assign bus.out_valid   = (state_q == StFull);
  assign bus.out_ctrl    = ctrl_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_rs1     = rs1_q;
  assign bus.out_rs2     = rs2_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_illegal = illegal_q;
  assign bus.out_muldiv  = muldiv_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus a random stall run against a stream model.
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam int unsigned IQ_DEPTH = 4;
  localparam int unsigned PC_W     = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [2:0] q_count;

  decode_stage_if #(.PC_W(PC_W)) bus ();

  decode_stage #(.IQ_DEPTH(IQ_DEPTH), .PC_W(PC_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .bus     (bus),
    .q_count (q_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference decoder written directly from the ISA field rules.
  function automatic logic [63:0] model_ctrl(input logic [31:0] w, output logic ill,
                                             output logic md);
    decoder_out_t c;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] ii;
    f3 = w[14:12];
    f7 = w[31:25];
    ii = 32'($signed(w) >>> 20);
    c = '0;
    c.func3 = f3;
    ill = 1'b0;
    md  = 1'b0;
    case (w[6:0])
      7'h37: begin c.imm = {w[31:12], 12'h0}; c.aluin1_m = 1; c.aluImm_m = 1; c.Wreg = 1; end
      7'h17: begin c.imm = {w[31:12], 12'h0}; c.aluPC_m = 1; c.aluImm_m = 1; c.Wreg = 1; end
      7'h6f: begin
        c.imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
        c.aluPC_m = 1; c.aluin2_m = 1; c.Wreg = 1; c.branch_type = BrJal;
      end
      7'h67: begin
        c.imm = ii; c.aluPC_m = 1; c.aluin2_m = 1; c.Wreg = 1; c.branch_type = BrJalr;
        ill = (f3 != 0);
      end
      7'h63: begin
        c.imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
        c.alu_codes = AluSub; c.branch_type = BrCond;
        ill = (f3 == 2) || (f3 == 3);
      end
      7'h03: begin
        c.imm = ii; c.aluImm_m = 1; c.Wreg = 1; c.isLoad = 1; c.Rmem = 1;
        ill = (f3 == 3) || (f3 >= 6);
      end
      7'h23: begin c.imm = {ii[31:5], w[11:7]}; c.aluImm_m = 1; c.Wmem = 1; ill = (f3 >= 3); end
      7'h13: begin
        c.imm = ii; c.aluImm_m = 1; c.Wreg = 1;
        c.alu_codes = (f3 == 5) ? {w[30], f3} : (f3 == 3) ? 4'b1011 : {1'b0, f3};
        ill = ((f3 == 1) && (f7 != 0)) || ((f3 == 5) && (f7 != 0) && (f7 != 7'h20));
      end
      7'h33: begin
        c.Wreg = 1;
        c.alu_codes = {w[30], f3};
`ifdef DECODE_RV32M_EN
        if (f7 == 7'h01) begin md = 1; c.alu_codes = AluAdd; end
        else ill = !((f7 == 0) || ((f7 == 7'h20) && (f3 == 0 || f3 == 5)));
`else
        ill = !((f7 == 0) || ((f7 == 7'h20) && (f3 == 0 || f3 == 5)));
`endif
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      c = '0;
      c.func3 = f3;
      c.alu_codes = {w[30], f3};
      md = 1'b0;
    end
    return 64'(c);
  endfunction

  // Stream model: words accepted and not yet consumed, oldest first (head = output register).
  logic [63:0] exp_q[$];
  int          mq = 0;
  bit          mov = 1'b0;
  int          n_out = 0;

  always @(posedge clk) begin : model
    bit push, cons, load;
    if (rst || flush) begin
      mq = 0;
      mov = 1'b0;
      exp_q.delete();
    end else begin
      push = bus.in_valid && (mq != IQ_DEPTH);
      cons = mov && bus.out_ready;
      load = (mq > 0) && (!mov || bus.out_ready);
      if (cons) begin
        void'(exp_q.pop_front());
        n_out++;
      end
      if (push) exp_q.push_back({bus.in_pc, bus.in_instr});
      mq  = mq + int'(push) - int'(load);
      mov = load || (mov && !bus.out_ready);
    end
  end

  logic [63:0] stall_ctrl;
  logic [31:0] stall_pc;
  bit          stalled = 1'b0;

  always @(negedge clk) begin : compare
    logic [31:0] w;
    logic        ill, md;
    logic [63:0] ec;
    if (!rst) begin
      check("q_count", 64'(q_count), 64'(mq));
      check("out_valid", 64'(bus.out_valid), 64'(mov));
      check("in_ready", 64'(bus.in_ready), 64'(mq != IQ_DEPTH));
      if (mov && exp_q.size() > 0) begin
        w  = exp_q[0][31:0];
        ec = model_ctrl(w, ill, md);
        check("out_ctrl", 64'(bus.out_ctrl), ec);
        check("out_rd", 64'(bus.out_rd), 64'(w[11:7]));
        check("out_rs1", 64'(bus.out_rs1), 64'(w[19:15]));
        check("out_rs2", 64'(bus.out_rs2), 64'(w[24:20]));
        check("out_pc", 64'(bus.out_pc), 64'(exp_q[0][63:32]));
        check("out_illegal", 64'(bus.out_illegal), 64'(ill));
        check("out_muldiv", 64'(bus.out_muldiv), 64'(md));
      end
      if (stalled) begin
        check("stall_ctrl", 64'(bus.out_ctrl), stall_ctrl);
        check("stall_pc", 64'(bus.out_pc), 64'(stall_pc));
      end
      stalled    = bus.out_valid && !bus.out_ready && !flush;
      stall_ctrl = 64'(bus.out_ctrl);
      stall_pc   = bus.out_pc;
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] words [16] = '{
    32'h00500093, 32'h00000000, 32'h0000306f, 32'h02208033,
    32'h123450b7, 32'h00001117, 32'h0020a223, 32'h0040a183,
    32'hfe208ee3, 32'h40208033, 32'h4010d093, 32'h000080e7,
    32'h000090e7, 32'h0200d093, 32'h0010b093, 32'hff010113
  };

  initial begin
    int n0, acc, cyc;
    logic ill_exp;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    check("rst q_count", 64'(q_count), 64'd0);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst in_ready", 64'(bus.in_ready), 64'd1);
    check("rst out_ctrl", 64'(bus.out_ctrl), 64'd0);
    check("rst out_pc", 64'(bus.out_pc), 64'd0);

    // addi x1,x0,5 at 0x100
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_instr = 32'h00500093; bus.in_pc = 32'h100;
    step();
    bus.in_valid = 1'b0;
    step();
    check("addi valid", 64'(bus.out_valid), 64'd1);
    check("addi imm", 64'(bus.out_ctrl.imm), 64'd5);
    check("addi rd", 64'(bus.out_rd), 64'd1);
    check("addi Wreg", 64'(bus.out_ctrl.Wreg), 64'd1);
    check("addi aluImm_m", 64'(bus.out_ctrl.aluImm_m), 64'd1);
    check("addi pc", 64'(bus.out_pc), 64'h100);
    check("addi illegal", 64'(bus.out_illegal), 64'd0);
    step();

    // Fill with the output stalled: 5 of 6 accepted
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h00000093 | (32'(i + 1) << 20);
      bus.in_pc    = 32'h300 + 32'(4 * i);
      step();
    end
    bus.in_valid = 1'b0;
    check("full q_count", 64'(q_count), 64'd4);
    check("full in_ready", 64'(bus.in_ready), 64'd0);
    check("full head pc", 64'(bus.out_pc), 64'h300);
    bus.out_ready = 1'b1;
    n0 = n_out;
    repeat (5) step();
    check("drain count", 64'(n_out - n0), 64'd5);
    check("drain empty", 64'(bus.out_valid), 64'd0);

    // Flush with three queued and a same-cycle word offered
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_instr = words[4 + i]; bus.in_pc = 32'h400 + 32'(4 * i);
      step();
    end
    check("preflush q_count", 64'(q_count), 64'd3);
    flush = 1'b1; bus.in_instr = 32'h7ff00293; bus.in_pc = 32'h500;
    step();
    flush = 1'b0; bus.in_valid = 1'b0;
    check("flush q_count", 64'(q_count), 64'd0);
    check("flush out_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    repeat (3) step();
    check("flush dropped", 64'(bus.out_valid), 64'd0);

    // All-zero word then jal with nonzero func3
    bus.in_valid = 1'b1; bus.in_instr = 32'h00000000; bus.in_pc = 32'h200;
    step();
    bus.in_instr = 32'h0000306f; bus.in_pc = 32'h204;
    step();
    bus.in_valid = 1'b0;
    check("zero illegal", 64'(bus.out_illegal), 64'd1);
    check("zero Wreg", 64'(bus.out_ctrl.Wreg), 64'd0);
    check("zero Wmem", 64'(bus.out_ctrl.Wmem), 64'd0);
    step();
    check("jal illegal", 64'(bus.out_illegal), 64'd0);
    check("jal Wreg", 64'(bus.out_ctrl.Wreg), 64'd1);
    check("jal pc", 64'(bus.out_pc), 64'h204);

    // mul x0,x1,x2
    bus.in_valid = 1'b1; bus.in_instr = 32'h02208033; bus.in_pc = 32'h208;
    step();
    bus.in_valid = 1'b0;
    step();
`ifdef DECODE_RV32M_EN
    ill_exp = 1'b0;
`else
    ill_exp = 1'b1;
`endif
    check("mul illegal", 64'(bus.out_illegal), 64'(ill_exp));
    check("mul muldiv", 64'(bus.out_muldiv), 64'(!ill_exp));
    step();

    // Random stalls over 1000 accepted words
    acc = 0;
    cyc = 0;
    n0 = n_out;
    while (acc < 1000 && cyc < 20000) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr  = ($urandom_range(0, 3) == 0) ? $urandom : words[$urandom_range(0, 15)];
      bus.in_pc     = 32'h1000 + 32'(4 * acc);
      #1;
      if (bus.in_valid && bus.in_ready) acc++;
      step();
      cyc++;
    end
    check("random accepted", 64'(acc), 64'd1000);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cyc = 0;
    while (bus.out_valid || q_count != 0) begin
      step();
      cyc++;
      if (cyc > 50) break;
    end
    check("random delivered", 64'(n_out - n0), 64'd1000);
    check("random model empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
